reg_wr_sched: RTL and testbench
===============================

Name: reg_wr_sched

Overview:
- Write-port scheduler for the dual-port general-purpose register array.
- Accepts register writeback requests from up to n_req datapath sources (ALU, load unit, etc.) over a valid/ready handshake.
- Each cycle it grants at most two requests, round-robin, and drives the array's Port I and Port II write controls from registers.
- Guarantees both write ports never target the same address in the same cycle, so the array's collision fault flag never sets.

Parameters:
- width, 16, register data width
- add_width, 3, register address width
- n_req, 4, number of requesters (2..8)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  n_req  per-requester write request
- req_add  in  n_req*add_width  packed addresses; requester i at bits [i*add_width +: add_width]
- req_data  in  n_req*width  packed write data; requester i at bits [i*width +: width]
- req_ready  out  n_req  combinational grant; transfer when valid && ready
- we1, we2  out  1  registered write enables, Port I / Port II
- add1, add2  out  add_width  registered write addresses
- wr1, wr2  out  width  registered write data
- sched_stall  out  1  combinational; a valid request exists that is not granted this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - we1, we2, add1, add2, wr1, wr2 and rr_ptr all go to 0.
  - req_ready is forced 0 while rst=1, so no transfers occur during reset.
- Grant A (Port I): the first valid requester scanning from rr_ptr upward, wrapping modulo n_req.
- Grant B (Port II): the next valid requester after A in the same scan order whose address differs from A's address.
- Same-address losers get no ready and must retry. Several valid requests to A's address means only A is granted.
- Requester obligation: hold valid, address and data stable until ready. Ready may assert in the same cycle as valid.
- Latency: one cycle. A handshake at edge N puts we/add/wr on the ports after edge N; the array commits at edge N+1.
- No grant: we1=we2=0 for that cycle; add and data hold their previous values.
- Single grant: only Port I is used; we2=0.
- rr_ptr update:
  - any grant: rr_ptr <= (index of last grant + 1) mod n_req
  - no grant: rr_ptr unchanged
- Fairness: a continuously valid requester is granted within n_req cycles.
- Invariant: (we1 && we2) implies add1 != add2, in every cycle.
- Reset asserted mid-stream: in-flight registered writes are dropped (we forced 0) and rr_ptr returns to 0.
- Ordering: grants to different requesters in one cycle are unordered. Ordering between same-address writers is by grant cycle.

Optional Feature:
- Macro: REG_WR_COLL_CNT_EN.
- Defined:
  - Adds output coll_cnt [7:0].
  - Increments once per cycle in which at least one valid request is denied solely because its address equals grant A's address.
  - Saturates at 8'hFF; cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package neptune_rf_pkg holds:
  - default width, add_width, n_req
  - requester index width, as the clog2 of n_req
- Sub-module rr_pick: rotate-priority first-one finder, taking mask, start index and returning found flag and index.
  - Instance 1 finds A.
  - Instance 2 finds B, on a mask with A and same-address requests cleared, starting at A+1.

Test Plan:
- Reset check: rst=1 with all requests valid -> req_ready=0000, we1=we2=0. Release -> first grants are req0 and req1 (rr_ptr=0).
- Dual grant: req0 (add=2, data=16'h1111) and req2 (add=5, data=16'h2222) valid, rr_ptr=0:
  - ready=0101
  - next cycle: we1=1, add1=2, wr1=16'h1111, we2=1, add2=5, wr2=16'h2222
  - rr_ptr=3
- Address conflict: req1 and req3 both add=4, rr_ptr=1:
  - ready=0010, sched_stall=1, we2=0
  - next cycle req3 is granted alone
  - with REG_WR_COLL_CNT_EN, coll_cnt=1
- Fairness: all 4 requesters valid for 8 cycles with distinct addresses -> each granted exactly 4 times, grant pairs rotating (0,1),(2,3),(0,1)...
- Idle and hold: no requests for 3 cycles -> we1=we2=0 while add1/wr1 hold their last values, and rr_ptr is unchanged.
- Mid-stream reset: rst pulsed in the cycle after a dual grant -> we1=we2=0 on the next cycle, and rr_ptr=0 on the following arbitration.

Source files
------------

// File: rtl/neptune_rf_pkg.sv
// Shared defaults for the register-file write scheduler.
// Requester index width derives from the requester count.
package neptune_rf_pkg;

    localparam int WIDTH     = 16;
    localparam int ADD_WIDTH = 3;
    localparam int N_REQ     = 4;
    localparam int REQ_IW    = $clog2(N_REQ);

    function automatic int req_iw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority first-one finder: first set mask bit
// at or after start_i, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int j;

    // Scan from the far end so the nearest hit wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start_i) + k;
            if (j >= N) j = j - N;
            if (mask_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_wr_sched.sv
// Dual write-port scheduler for the GPR array, round-robin, two grants/cycle.
// Optional REG_WR_COLL_CNT_EN adds a saturating same-address denial counter.
module reg_wr_sched
    import neptune_rf_pkg::*;
#(
    parameter int width     = WIDTH,
    parameter int add_width = ADD_WIDTH,
    parameter int n_req     = N_REQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [n_req-1:0]           req_valid,
    input  logic [n_req*add_width-1:0] req_add,
    input  logic [n_req*width-1:0]     req_data,
    output logic [n_req-1:0]           req_ready,
    output logic                       we1,
    output logic                       we2,
    output logic [add_width-1:0]       add1,
    output logic [add_width-1:0]       add2,
    output logic [width-1:0]           wr1,
    output logic [width-1:0]           wr2,
    output logic                       sched_stall
`ifdef REG_WR_COLL_CNT_EN
    ,
    output logic [7:0]                 coll_cnt
`endif
);

    localparam int IW = req_iw(n_req);

    logic [add_width-1:0] addr [n_req];
    logic [width-1:0]     data [n_req];

    logic                 a_found, b_found;
    logic [IW-1:0]        a_idx, b_idx, b_start;
    logic [IW-1:0]        last_idx;
    logic [add_width-1:0] add_a;
    logic [n_req-1:0]     mask_b;
    logic                 coll_hit;

    logic                 we1_q, we2_q;
    logic [add_width-1:0] add1_q, add2_q;
    logic [width-1:0]     wr1_q, wr2_q;
    logic [IW-1:0]        rr_q, rr_d;

    always_comb begin
        for (int i = 0; i < n_req; i++) begin
            addr[i] = req_add[i*add_width +: add_width];
            data[i] = req_data[i*width +: width];
        end
    end

    rr_pick #(.N(n_req), .IW(IW)) u_pick_a (
        .mask_i  (req_valid),
        .start_i (rr_q),
        .found_o (a_found),
        .idx_o   (a_idx)
    );

    assign add_a   = addr[a_idx];
    assign b_start = (a_idx == IW'(n_req - 1)) ? '0 : a_idx + IW'(1);

    // Port II candidates exclude A and anything aliasing A's address.
    always_comb begin
        mask_b   = '0;
        coll_hit = 1'b0;
        for (int i = 0; i < n_req; i++) begin
            if (req_valid[i] && a_found && (IW'(i) != a_idx)) begin
                if (addr[i] == add_a) coll_hit = 1'b1;
                else                  mask_b[i] = 1'b1;
            end
        end
    end

    rr_pick #(.N(n_req), .IW(IW)) u_pick_b (
        .mask_i  (mask_b),
        .start_i (b_start),
        .found_o (b_found),
        .idx_o   (b_idx)
    );

    always_comb begin
        for (int i = 0; i < n_req; i++) begin
            req_ready[i] = !rst &&
                ((a_found && (a_idx == IW'(i))) ||
                 (b_found && (b_idx == IW'(i))));
        end
    end

    assign sched_stall = |(req_valid & ~req_ready);

    assign last_idx = b_found ? b_idx : a_idx;

    always_comb begin
        rr_d = rr_q;
        if (a_found)
            rr_d = (last_idx == IW'(n_req - 1)) ? '0 : last_idx + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we1_q  <= 1'b0;
            we2_q  <= 1'b0;
            add1_q <= '0;
            add2_q <= '0;
            wr1_q  <= '0;
            wr2_q  <= '0;
            rr_q   <= '0;
        end else begin
            we1_q <= a_found;
            we2_q <= b_found;
            rr_q  <= rr_d;
            if (a_found) begin
                add1_q <= add_a;
                wr1_q  <= data[a_idx];
            end
            if (b_found) begin
                add2_q <= addr[b_idx];
                wr2_q  <= data[b_idx];
            end
        end
    end

    assign we1  = we1_q;
    assign we2  = we2_q;
    assign add1 = add1_q;
    assign add2 = add2_q;
    assign wr1  = wr1_q;
    assign wr2  = wr2_q;

`ifdef REG_WR_COLL_CNT_EN
    logic [7:0] coll_q;

    always_ff @(posedge clk) begin
        if (rst)
            coll_q <= '0;
        else if (coll_hit && (coll_q != 8'hFF))
            coll_q <= coll_q + 8'd1;
    end

    assign coll_cnt = coll_q;
`endif

endmodule

// File: tb/tb_reg_wr_sched.sv
// Bench for reg_wr_sched: directed scenarios plus randomized traffic
// against a scan-order reference model.
module tb_reg_wr_sched;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_add;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            we1, we2;
    logic [AW-1:0]   add1, add2;
    logic [DW-1:0]   wr1, wr2;
    logic            sched_stall;
`ifdef REG_WR_COLL_CNT_EN
    logic [7:0]      coll_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_wr_sched #(.width(DW), .add_width(AW), .n_req(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_add     (req_add),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .we1         (we1),
        .we2         (we2),
        .add1        (add1),
        .add2        (add2),
        .wr1         (wr1),
        .wr2         (wr2),
        .sched_stall (sched_stall)
`ifdef REG_WR_COLL_CNT_EN
        ,
        .coll_cnt    (coll_cnt)
`endif
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: walk requesters in scan order from ptr.
    function automatic void mgrant(
        input  logic [N-1:0]    v,
        input  logic [N*AW-1:0] ad,
        input  int              ptr,
        output bit af, output int a,
        output bit bf, output int b,
        output bit coll);
        int j;
        af = 0; bf = 0; a = 0; b = 0; coll = 0;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (v[j]) begin
                if (!af) begin
                    af = 1; a = j;
                end else if (ad[j*AW +: AW] == ad[a*AW +: AW]) begin
                    coll = 1;
                end else if (!bf) begin
                    bf = 1; b = j;
                end
            end
        end
    endfunction

    bit            armed = 0;
    bit            m_we1, m_we2;
    logic [AW-1:0] m_add1, m_add2;
    logic [DW-1:0] m_wr1, m_wr2;
    int            m_ptr;
    int            m_coll;

    always @(posedge clk) begin
        bit af, bf, cl;
        int a, b;
        if (rst) begin
            armed = 1;
            m_we1 = 0; m_we2 = 0;
            m_add1 = '0; m_add2 = '0;
            m_wr1 = '0; m_wr2 = '0;
            m_ptr = 0; m_coll = 0;
        end else if (armed) begin
            mgrant(req_valid, req_add, m_ptr, af, a, bf, b, cl);
            m_we1 = af;
            m_we2 = bf;
            if (af) begin
                m_add1 = req_add[a*AW +: AW];
                m_wr1  = req_data[a*DW +: DW];
                m_ptr  = ((bf ? b : a) + 1) % N;
            end
            if (bf) begin
                m_add2 = req_add[b*AW +: AW];
                m_wr2  = req_data[b*DW +: DW];
            end
            if (cl && m_coll < 255) m_coll++;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        bit af, bf, cl;
        int a, b;
        logic [N-1:0] e_rdy;
        if (armed) begin
            mgrant(req_valid, req_add, m_ptr, af, a, bf, b, cl);
            e_rdy = '0;
            if (!rst) begin
                if (af) e_rdy[a] = 1'b1;
                if (bf) e_rdy[b] = 1'b1;
            end
            chk("req_ready", req_ready, e_rdy);
            chk("sched_stall", sched_stall, |(req_valid & ~e_rdy));
            chk("we1", we1, m_we1);
            chk("we2", we2, m_we2);
            chk("add1", add1, m_add1);
            chk("add2", add2, m_add2);
            chk("wr1", wr1, m_wr1);
            chk("wr2", wr2, m_wr2);
            if (we1 && we2)
                chk("port_collision", (add1 == add2), 0);
`ifdef REG_WR_COLL_CNT_EN
            chk("coll_cnt", coll_cnt, m_coll);
`endif
        end
    end

    logic [N-1:0] s_ready;
    logic         s_stall;

    task automatic tick();
        @(negedge clk);
        s_ready = req_ready;
        s_stall = sched_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_add[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic distinct_all();
        for (int i = 0; i < N; i++)
            set_req(i, AW'(i), DW'(16'hA000 + i));
        req_valid = '1;
    endtask

    int cnt [N];
    bit pend [N];

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_add = '0;
        req_data = '0;
        distinct_all();
        tick();
        tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_we1", we1, 0);
        chk("rst_we2", we2, 0);

        // Fairness: all valid, distinct addresses, 8 cycles.
        rst = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("fair_pair", s_ready, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < N; i++) if (s_ready[i]) cnt[i]++;
        end
        for (int i = 0; i < N; i++) chk("fair_count", cnt[i], 4);

        // Dual grant from rr_ptr=0.
        req_valid = 4'b0101;
        set_req(0, 3'd2, 16'h1111);
        set_req(2, 3'd5, 16'h2222);
        tick();
        chk("dual_ready", s_ready, 4'b0101);
        chk("dual_we1", we1, 1);
        chk("dual_add1", add1, 2);
        chk("dual_wr1", wr1, 16'h1111);
        chk("dual_we2", we2, 1);
        chk("dual_add2", add2, 5);
        chk("dual_wr2", wr2, 16'h2222);

        // rr_ptr=3 means req3 takes Port I ahead of req0.
        req_valid = 4'b1001;
        set_req(3, 3'd7, 16'h3333);
        set_req(0, 3'd6, 16'h4444);
        tick();
        chk("ptr3_add1", add1, 7);
        chk("ptr3_wr1", wr1, 16'h3333);
        chk("ptr3_add2", add2, 6);

        // Same-address conflict from rr_ptr=1.
        req_valid = 4'b1010;
        set_req(1, 3'd4, 16'h5555);
        set_req(3, 3'd4, 16'h6666);
        tick();
        chk("conf_ready", s_ready, 4'b0010);
        chk("conf_stall", s_stall, 1);
        chk("conf_wr1", wr1, 16'h5555);
        chk("conf_we2", we2, 0);
`ifdef REG_WR_COLL_CNT_EN
        chk("conf_coll_cnt", coll_cnt, 1);
`endif
        req_valid = 4'b1000;
        tick();
        chk("retry_ready", s_ready, 4'b1000);
        chk("retry_wr1", wr1, 16'h6666);
        chk("retry_we2", we2, 0);

        // Idle: ports hold address/data, enables drop.
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_ready", s_ready, 0);
            chk("idle_we1", we1, 0);
            chk("idle_add1", add1, 4);
            chk("idle_wr1", wr1, 16'h6666);
        end
        distinct_all();
        tick();
        chk("idle_ptr", s_ready, 4'b0011);

        // Reset right after a dual grant.
        rst = 1'b1;
        tick();
        chk("mrst_ready", s_ready, 0);
        chk("mrst_we1", we1, 0);
        chk("mrst_we2", we2, 0);
        rst = 1'b0;
        tick();
        chk("mrst_ptr", s_ready, 4'b0011);

        // Randomized traffic with hold-until-ready requesters.
        req_valid = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && req_valid[i] && s_ready[i]) pend[i] = 0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    set_req(i, AW'($urandom_range(0, 3)), DW'($urandom));
                end
                req_valid[i] = pend[i];
            end
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
